// File: rtl/key_sched_ctrl.sv
// DES key-schedule sequencer: walks the C/D rotation table forward (encrypt)
// or backward with right rotations (decrypt), one pair per accepted handshake.
module key_sched_ctrl #(
  parameter int unsigned WIDTH      = 28,
  parameter logic [15:0] SHIFT_MASK = 16'b1000_0001_0000_0011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             decrypt,
  input  logic             abort,
  input  logic [WIDTH-1:0] key_c,
  input  logic [WIDTH-1:0] key_d,
  input  logic             ready,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [4:0]       round,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [4:0]       round_q, round_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mode_q, mode_d;

  logic [3:0]       enc_idx;
  logic [3:0]       dec_idx;
  logic             enc_two;
  logic             dec_two;
  logic             first_two;
  logic             accept;

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x,
                                            input logic two);
    return two ? {x[WIDTH-3:0], x[WIDTH-1:WIDTH-2]}
               : {x[WIDTH-2:0], x[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x,
                                            input logic two);
    return two ? {x[1:0], x[WIDTH-1:2]}
               : {x[0], x[WIDTH-1:1]};
  endfunction

  // Advancing from round r to r+1: encrypt uses s(r+1) -> mask bit r;
  // decrypt uses s(17-r) -> mask bit 16-r (table walked 16,15,...,2).
  assign enc_idx   = round_q[3:0];
  assign dec_idx   = 4'(5'd16 - round_q);
  assign enc_two   = ~SHIFT_MASK[enc_idx];
  assign dec_two   = ~SHIFT_MASK[dec_idx];
  assign first_two = ~SHIFT_MASK[0];
  assign accept    = valid_q & ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mode_d  = mode_q;

    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          mode_d  = decrypt;
          round_d = 5'd1;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = RUN;
          // Decrypt starts at C16/D16, which equal C0/D0 after a full 28-bit turn.
          if (decrypt) begin
            c_d = key_c;
            d_d = key_d;
          end else begin
            c_d = rotl(key_c, first_two);
            d_d = rotl(key_d, first_two);
          end
        end
      end

      RUN: begin
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          round_d = '0;
        end else if (accept) begin
          if (round_q == 5'd16) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            round_d = '0;
            done_d  = 1'b1;
          end else begin
            round_d = round_q + 5'd1;
            if (mode_q) begin
              c_d = rotr(c_q, dec_two);
              d_d = rotr(d_q, dec_two);
            end else begin
              c_d = rotl(c_q, enc_two);
              d_d = rotl(d_q, enc_two);
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign c     = c_q;
  assign d     = d_q;
  assign round = round_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Directed bench for key_sched_ctrl: encrypt/decrypt sequences, stalls,
// ignored start, back-to-back start, abort and asynchronous reset.
module tb_key_sched_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        decrypt;
  logic        abort;
  logic [27:0] key_c;
  logic [27:0] key_d;
  logic        ready;
  logic [27:0] c;
  logic [27:0] d;
  logic [4:0]  round;
  logic        valid;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Encrypt pairs for C0=0000001, D0=8000000; cumulative left rotation
  // per round is 1,2,4,6,8,10,12,14,15,17,19,21,23,25,27,28.
  logic [27:0] enc_c [1:16];
  logic [27:0] enc_d [1:16];

  key_sched_ctrl #(
    .WIDTH(28),
    .SHIFT_MASK(16'b1000_0001_0000_0011)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .decrypt(decrypt),
    .abort(abort),
    .key_c(key_c),
    .key_d(key_d),
    .ready(ready),
    .c(c),
    .d(d),
    .round(round),
    .valid(valid),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int r, input logic [27:0] ec,
                         input logic [27:0] ed, input logic ev, input logic eb,
                         input logic edn);
    check($sformatf("%s_r%0d_round", tag, r), 32'(round), 32'(r));
    check($sformatf("%s_r%0d_c", tag, r), 32'(c), 32'(ec));
    check($sformatf("%s_r%0d_d", tag, r), 32'(d), 32'(ed));
    check($sformatf("%s_r%0d_valid", tag, r), 32'(valid), 32'(ev));
    check($sformatf("%s_r%0d_busy", tag, r), 32'(busy), 32'(eb));
    check($sformatf("%s_r%0d_done", tag, r), 32'(done), 32'(edn));
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_round"}, 32'(round), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    enc_c = '{28'h0000002, 28'h0000004, 28'h0000010, 28'h0000040,
              28'h0000100, 28'h0000400, 28'h0001000, 28'h0004000,
              28'h0008000, 28'h0020000, 28'h0080000, 28'h0200000,
              28'h0800000, 28'h2000000, 28'h8000000, 28'h0000001};
    enc_d = '{28'h0000001, 28'h0000002, 28'h0000008, 28'h0000020,
              28'h0000080, 28'h0000200, 28'h0000800, 28'h0002000,
              28'h0004000, 28'h0010000, 28'h0040000, 28'h0100000,
              28'h0400000, 28'h1000000, 28'h4000000, 28'h8000000};

    rst     = 1'b1;
    start   = 1'b0;
    decrypt = 1'b0;
    abort   = 1'b0;
    key_c   = 28'h0000001;
    key_d   = 28'h8000000;
    ready   = 1'b1;

    #12;
    chk_all("reset", 0, 28'h0, 28'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk_idle("idle_after_reset");

    // Encrypt, no stalls
    start = 1'b1;
    step();
    start = 1'b0;
    for (int r = 1; r <= 16; r++) begin
      chk_all("enc", r, enc_c[r], enc_d[r], 1'b1, 1'b1, 1'b0);
      step();
    end
    chk_all("enc_done", 0, 28'h0000001, 28'h8000000, 1'b0, 1'b0, 1'b1);
    step();
    chk_all("enc_after", 0, 28'h0000001, 28'h8000000, 1'b0, 1'b0, 1'b0);

    // Decrypt: round r shows encrypt pair 17-r (pair 16 equals the key)
    decrypt = 1'b1;
    start   = 1'b1;
    step();
    start   = 1'b0;
    decrypt = 1'b0;
    for (int r = 1; r <= 16; r++) begin
      chk_all("dec", r, enc_c[17-r], enc_d[17-r], 1'b1, 1'b1, 1'b0);
      step();
    end
    chk_all("dec_done", 0, 28'h0000002, 28'h0000001, 1'b0, 1'b0, 1'b1);

    // Back-to-back start in the done cycle
    start = 1'b1;
    step();
    start = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      chk_all("b2b", r, enc_c[r], enc_d[r], 1'b1, 1'b1, 1'b0);
      step();
    end
    chk_all("stall_pre", 4, enc_c[4], enc_d[4], 1'b1, 1'b1, 1'b0);

    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all("stall", 4, enc_c[4], enc_d[4], 1'b1, 1'b1, 1'b0);
    end
    ready = 1'b1;
    step();
    chk_all("resume", 5, enc_c[5], enc_d[5], 1'b1, 1'b1, 1'b0);
    step();
    chk_all("resume", 6, enc_c[6], enc_d[6], 1'b1, 1'b1, 1'b0);
    step();
    chk_all("resume", 7, enc_c[7], enc_d[7], 1'b1, 1'b1, 1'b0);

    // start/mode/key changes while busy must be ignored
    start   = 1'b1;
    decrypt = 1'b1;
    key_c   = 28'hABCDEF1;
    key_d   = 28'h1234567;
    step();
    start   = 1'b0;
    decrypt = 1'b0;
    chk_all("ign_start", 8, enc_c[8], enc_d[8], 1'b1, 1'b1, 1'b0);
    key_c   = 28'h0000001;
    key_d   = 28'h8000000;
    step();
    chk_all("ign_start", 9, enc_c[9], enc_d[9], 1'b1, 1'b1, 1'b0);

    // Abort wins over a simultaneous handshake
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("abort");
    step();
    chk_idle("abort_nodone");

    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("abort_idle");

    // Clean schedule after abort, then async reset mid-cycle in round 5
    start = 1'b1;
    step();
    start = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      chk_all("post_abort", r, enc_c[r], enc_d[r], 1'b1, 1'b1, 1'b0);
      step();
    end
    chk_all("pre_rst", 5, enc_c[5], enc_d[5], 1'b1, 1'b1, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 28'h0, 28'h0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    step();
    chk_all("rst_idle", 0, 28'h0, 28'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("rst_idle2", 0, 28'h0, 28'h0, 1'b0, 1'b0, 1'b0);

    start = 1'b1;
    step();
    start = 1'b0;
    chk_all("restart", 1, enc_c[1], enc_d[1], 1'b1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
